// File: rtl/alu_result_display_if.sv
// Producer-side handshake into alu_result_display.
// ALU_DISPLAY_HEX_MODE_EN adds the hex_mode qualifier that travels with in_data.
interface alu_result_display_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
`ifdef ALU_DISPLAY_HEX_MODE_EN
  logic       hex_mode;

  modport master (
    output in_valid,
    output in_data,
    output hex_mode,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  hex_mode,
    output in_ready
  );
`else
  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
`endif
endinterface

// File: rtl/alu_result_display.sv
// Shows an 8-bit ALU result on three scanned active-low 7-segment digits via a double-dabble BCD FSM.
// Optional ALU_DISPLAY_HEX_MODE_EN: per-value hex_mode bypasses conversion and shows two hex digits.
module alu_result_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic                 clock,
  input  logic                 reset,
  alu_result_display_if.slave  bus,
  output logic                 busy,
  output logic [2:0]           digit_en,
  output logic [6:0]           seg
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_CONVERT = 1'b1;

  localparam int              CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  logic [0:0]       state_reg,    state_next;
  logic [19:0]      shift_reg,    shift_next;
  logic [3:0]       bit_cnt_reg,  bit_cnt_next;
  logic [11:0]      disp_reg,     disp_next;
  logic             hex_reg,      hex_next;
  logic [CNT_W-1:0] scan_cnt_reg, scan_cnt_next;
  logic [1:0]       idx_reg,      idx_next;
  logic [2:0]       digit_en_reg, digit_en_next;
  logic [6:0]       seg_reg,      seg_next;

  logic        accept;
  logic        take_hex;
  logic [19:0] adjusted;
  logic        scan_wrap;
  logic [3:0]  digit_nib;
  logic        digit_blank;

  assign bus.in_ready = (state_reg == ST_IDLE);
  assign busy         = (state_reg == ST_CONVERT);
  assign accept       = bus.in_valid & bus.in_ready;
  assign digit_en     = digit_en_reg;
  assign seg          = seg_reg;

`ifdef ALU_DISPLAY_HEX_MODE_EN
  assign take_hex = bus.hex_mode;
`else
  assign take_hex = 1'b0;
`endif

  // Add-3 correction applied to each BCD nibble before the shift.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dabble
      assign adjusted[8 + 4*gi +: 4] = (shift_reg[8 + 4*gi +: 4] >= 4'd5)
                                     ? shift_reg[8 + 4*gi +: 4] + 4'd3
                                     : shift_reg[8 + 4*gi +: 4];
    end
  endgenerate
  assign adjusted[7:0] = shift_reg[7:0];

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    disp_next    = disp_reg;
    hex_next     = hex_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (take_hex) begin
            disp_next = {4'h0, bus.in_data};
            hex_next  = 1'b1;
          end else begin
            shift_next   = {12'd0, bus.in_data};
            bit_cnt_next = 4'd0;
            state_next   = ST_CONVERT;
          end
        end
      end
      ST_CONVERT: begin
        shift_next   = adjusted << 1;
        bit_cnt_next = bit_cnt_reg + 4'd1;
        // The eighth shift completes the conversion; publish in the same edge.
        if (bit_cnt_reg == 4'd7) begin
          disp_next  = shift_next[19:8];
          hex_next   = 1'b0;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Scan timing runs freely, independent of the conversion FSM.
  assign scan_wrap     = (scan_cnt_reg == CNT_LAST);
  assign scan_cnt_next = scan_wrap ? '0 : scan_cnt_reg + 1'b1;

  always_comb begin
    idx_next = idx_reg;
    if (scan_wrap) begin
      idx_next = (idx_reg == 2'd2) ? 2'd0 : idx_reg + 2'd1;
    end
  end

  generate
    for (gi = 0; gi < 3; gi++) begin : g_digit_en
      assign digit_en_next[gi] = (idx_next == 2'(gi));
    end
  endgenerate

  // Pattern is taken from the next-cycle value so seg and digit_en stay paired.
  always_comb begin
    digit_nib   = disp_next[3:0];
    digit_blank = 1'b0;
    case (idx_next)
      2'd2: begin
        digit_nib   = disp_next[11:8];
        digit_blank = hex_next | (disp_next[11:8] == 4'd0);
      end
      2'd1: begin
        digit_nib   = disp_next[7:4];
        digit_blank = ~hex_next & (disp_next[11:8] == 4'd0) & (disp_next[7:4] == 4'd0);
      end
      default: begin
        digit_nib   = disp_next[3:0];
        digit_blank = 1'b0;
      end
    endcase
    seg_next = digit_blank ? SEG_BLANK : seg_pattern(digit_nib);
  end

  function automatic logic [6:0] seg_pattern(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b1000000;
      4'h1:    pat = 7'b1111001;
      4'h2:    pat = 7'b0100100;
      4'h3:    pat = 7'b0110000;
      4'h4:    pat = 7'b0011001;
      4'h5:    pat = 7'b0010010;
      4'h6:    pat = 7'b0000010;
      4'h7:    pat = 7'b1111000;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0010000;
      4'hA:    pat = 7'b0001000;
      4'hB:    pat = 7'b0000011;
      4'hC:    pat = 7'b1000110;
      4'hD:    pat = 7'b0100001;
      4'hE:    pat = 7'b0000110;
      default: pat = 7'b0001110;
    endcase
    return pat;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= 20'd0;
      bit_cnt_reg  <= 4'd0;
      disp_reg     <= 12'd0;
      hex_reg      <= 1'b0;
      scan_cnt_reg <= '0;
      idx_reg      <= 2'd0;
      digit_en_reg <= 3'b001;
      seg_reg      <= SEG_ZERO;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_cnt_reg  <= bit_cnt_next;
      disp_reg     <= disp_next;
      hex_reg      <= hex_next;
      scan_cnt_reg <= scan_cnt_next;
      idx_reg      <= idx_next;
      digit_en_reg <= digit_en_next;
      seg_reg      <= seg_next;
    end
  end

endmodule

// File: tb/tb_alu_result_display.sv
// Randomized self-checking bench for alu_result_display (SCAN_DIV=2) against a decimal/hex display model.
// Define ALU_DISPLAY_HEX_MODE_EN to also exercise hex_mode transfers.
module tb_alu_result_display;

  logic       clock;
  logic       reset;
  logic       busy;
  logic [2:0] digit_en;
  logic [6:0] seg;

  alu_result_display_if bus ();

  alu_result_display #(.SCAN_DIV(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .digit_en (digit_en),
    .seg      (seg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int check_count = 0;
  int error_count = 0;

  // Model state: value currently expected on the display and whether it is hex.
  int model_disp = 0;
  bit model_hex  = 1'b0;
  int scan_edges;

  logic [6:0] pat [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int idx, input int v, input bit hx);
    int h, t, u;
    if (hx) begin
      if (idx == 2) return 7'b1111111;
      if (idx == 1) return pat[(v / 16) % 16];
      return pat[v % 16];
    end
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    if (idx == 2) return (h == 0) ? 7'b1111111 : pat[h];
    if (idx == 1) return (h == 0 && t == 0) ? 7'b1111111 : pat[t];
    return pat[u];
  endfunction

  // Clock edges since reset release; each digit is held for two of them.
  always @(posedge clock or posedge reset) begin
    if (reset) scan_edges <= 0;
    else       scan_edges <= scan_edges + 1;
  end

  always @(negedge clock) begin
    if (!reset) begin
      check_value("scan_digit_en", {29'd0, digit_en}, 32'(3'b001 << ((scan_edges / 2) % 3)));
      check_value("scan_seg", {25'd0, seg}, {25'd0, exp_seg((scan_edges / 2) % 3, model_disp, model_hex)});
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send(input logic [7:0] v, input bit keep_valid, input bit hex);
    int waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    check_value("ready_before_send", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
`ifdef ALU_DISPLAY_HEX_MODE_EN
    bus.hex_mode = hex;
`endif
    @(posedge clock);
    if (hex) begin
      model_disp = int'(v);
      model_hex  = 1'b1;
      @(negedge clock);
      if (!keep_valid) bus.in_valid = 1'b0;
      check_value("hex_ready", {31'd0, bus.in_ready}, 32'd1);
      check_value("hex_busy", {31'd0, busy}, 32'd0);
    end else begin
      @(negedge clock);
      if (!keep_valid) bus.in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
        check_value("conv_ready", {31'd0, bus.in_ready}, 32'd0);
        check_value("conv_busy", {31'd0, busy}, 32'd1);
        if (i < 7) @(negedge clock);
      end
      @(posedge clock);
      model_disp = int'(v);
      model_hex  = 1'b0;
      @(negedge clock);
      check_value("done_ready", {31'd0, bus.in_ready}, 32'd1);
      check_value("done_busy", {31'd0, busy}, 32'd0);
    end
    $display("TXN value=%0d hex=%0d hold=%0d errors_so_far=%0d", v, hex, keep_valid, error_count);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fixed_vals [8] = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd101, 8'd110, 8'd199, 8'd250};
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
`ifdef ALU_DISPLAY_HEX_MODE_EN
    bus.hex_mode = 1'b0;
`endif
    repeat (3) @(negedge clock);
    #1;
    check_value("rst_digit_en", {29'd0, digit_en}, 32'b001);
    check_value("rst_seg", {25'd0, seg}, 32'b1000000);
    check_value("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    check_value("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    #2 reset = 1'b0;
    idle(8);

    send(8'd255, 1'b0, 1'b0);
    idle(6);
    send(8'd7, 1'b0, 1'b0);
    idle(6);
    send(8'd100, 1'b1, 1'b0);
    send(8'd42, 1'b0, 1'b0);
    idle(6);

    // Abort a conversion of 200 during its fourth CONVERT cycle.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd200;
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    model_disp = 0;
    model_hex  = 1'b0;
    #1;
    check_value("abort_digit_en", {29'd0, digit_en}, 32'b001);
    check_value("abort_seg", {25'd0, seg}, 32'b1000000);
    check_value("abort_ready", {31'd0, bus.in_ready}, 32'd1);
    check_value("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    #2 reset = 1'b0;
    $display("TXN reset during conversion of 200 errors_so_far=%0d", error_count);
    idle(12);

`ifdef ALU_DISPLAY_HEX_MODE_EN
    send(8'hA5, 1'b0, 1'b1);
    idle(6);
    send(8'h0C, 1'b0, 1'b1);
    idle(6);
    send(8'd5, 1'b0, 1'b0);
    idle(6);
`endif

    for (int i = 0; i < 8; i++) begin
      send(fixed_vals[i], 1'b0, 1'b0);
      idle(6);
    end

    for (int i = 0; i < 24; i++) begin
      logic [7:0] v;
      bit keep, hx;
      v    = 8'($urandom_range(0, 255));
      keep = (i < 23) ? 1'($urandom_range(0, 1)) : 1'b0;
`ifdef ALU_DISPLAY_HEX_MODE_EN
      hx = 1'($urandom_range(0, 1));
`else
      hx = 1'b0;
`endif
      send(v, keep, hx);
      if (!keep) idle(6);
    end
    bus.in_valid = 1'b0;
    idle(6);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
